cla16_arb_ctrl: RTL and testbench
=================================

// Module: cla16_arb_ctrl
// PURPOSE
//  Two-requester round-robin arbiter/sequencer for one shared 16-bit CLA
//  add/sub unit (bit16_cla). Accepts operations over valid/ready, drives the
//  adder from registered operands, captures sum/cout, adds signed overflow and
//  returns a tagged result over valid/ready. One op in flight; adder external.
// PARAMETERS
//  DW       16  operand/result width; must match the attached adder
//  RR_INIT  0   requester favoured first after reset (0 or 1)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  r0_valid   in   1   requester 0 has an op
//  r0_ready   out  1   op accepted from requester 0 this cycle
//  r0_a,r0_b  in   DW  requester 0 operands
//  r0_sub     in   1   1 = a-b, 0 = a+b(+cin)
//  r0_cin     in   1   carry-in (add only)
//  r1_*       -    -   identical set for requester 1
//  add_a      out  DW  adder ain
//  add_b      out  DW  adder bin
//  add_cin    out  1   adder cin
//  add_sub    out  1   adder sub
//  add_sum    in   DW  adder sum (combinational from add_*)
//  add_cout   in   1   adder cout
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer takes result
//  rsp_id     out  1   requester that issued the op
//  rsp_sum    out  DW  result
//  rsp_cout   out  1   carry out (sub: 1 = no borrow)
//  rsp_ovf    out  1   signed overflow
//  ops_done   out  16  completed-op count, wraps 0xFFFF->0
// BEHAVIOUR
//  States IDLE -> EXEC -> RESP -> IDLE; reset state IDLE.
//  Reset: rsp_valid=0, rsp_id/rsp_sum/rsp_cout/rsp_ovf=0, add_*=0, ops_done=0,
//   pointer=RR_INIT. Reset mid-op discards op; no response issued.
//  IDLE: rN_ready combinational = (state==IDLE) & grantN. Only one valid ->
//   grant it. Both valid -> grant pointer side. On handshake latch a,b,sub,cin,
//   id; go EXEC. No valid -> stay. r*_ready=0 in EXEC and RESP.
//  EXEC (1 cycle): add_a=opA, add_b=opB, add_sub=opSub, add_cin=opSub?0:opCin.
//   Capture add_sum/add_cout into rsp regs at end of cycle; go RESP.
//  add_* hold last driven value outside EXEC (no toggling when idle).
//  ovf: add: a[DW-1]==b[DW-1] && sum[DW-1]!=a[DW-1];
//       sub: a[DW-1]!=b[DW-1] && sum[DW-1]!=a[DW-1].
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready=1. On handshake:
//   rsp_valid=0 next cycle, ops_done+1, pointer = ~rsp_id, go IDLE.
//  Latency: accept cycle T -> rsp_valid at T+2. Max throughput 1 op / 3 cycles
//   with rsp_ready held high.
//  Pointer only moves on completed response; a requester dropping valid
//   while not granted is legal and loses nothing.
// TESTING
//  1 rst 2 cycles -> all outputs 0, no ready with no valid.
//  2 r0: a=32767,b=32768,add,cin=0 -> T+2 rsp_sum=65535,cout=0,ovf=0,id=0.
//  3 r1: a=32767,b=16384,add -> sum=49151,cout=0,ovf=1; a=50,b=100,sub ->
//    sum=0xFFCE,cout=0,ovf=0; a=100,b=100,sub -> sum=0,cout=1.
//  4 r0 and r1 valid continuously, RR_INIT=0 -> grants 0,1,0,1; ops_done=4
//    after four responses; r0 sub with cin=1 (15-7) -> sum=8 (cin ignored).
//  5 rsp_ready low 5 cycles -> rsp_* stable, no new ready; then high -> IDLE.
//  6 rst asserted in EXEC -> no rsp_valid, ops_done=0; ops_done wraps
//    0xFFFF->0 after preload run.

Source files
------------

// File: rtl/cla16_arb_ctrl.sv
// -----------------------------------------------------------------------------
// cla16_arb_ctrl
// Two-requester round-robin sequencer in front of one shared, external
// combinational CLA add/sub unit. It takes one operation at a time, drives the
// adder from registered operands for a single cycle, captures sum/carry, works
// out signed overflow and returns a tagged result.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   r0_* / r1_*                requester op channels (valid/ready, a, b, sub, cin)
//   add_a/add_b/add_cin/add_sub  registered drive to the external adder
//   add_sum/add_cout           combinational result from the external adder
//   rsp_valid/rsp_ready        result channel handshake
//   rsp_id/rsp_sum/rsp_cout/rsp_ovf  result payload (rsp_cout=1 on sub: no borrow)
//   ops_done                   completed-op counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module cla16_arb_ctrl #(
    parameter int DW      = 16,
    parameter int RR_INIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    input  logic          r0_sub,
    input  logic          r0_cin,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    input  logic          r1_sub,
    input  logic          r1_cin,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    output logic          add_cin,
    output logic          add_sub,
    input  logic [DW-1:0] add_sum,
    input  logic          add_cout,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_sum,
    output logic          rsp_cout,
    output logic          rsp_ovf,
    output logic [15:0]   ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic RR_INIT_BIT = (RR_INIT != 0);

    // Signed overflow: operands effectively share a sign (b is inverted for
    // subtract) and the result sign differs from a.
    function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic s_msb);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (sub ? ~same_sign : same_sign) & (s_msb != a_msb);
    endfunction

    state_t          state_r;
    logic            ptr_r;
    logic [DW-1:0]   add_a_r;
    logic [DW-1:0]   add_b_r;
    logic            add_cin_r;
    logic            add_sub_r;
    logic            op_id_r;
    logic            rsp_valid_r;
    logic            rsp_id_r;
    logic [DW-1:0]   rsp_sum_r;
    logic            rsp_cout_r;
    logic            rsp_ovf_r;
    logic [15:0]     ops_done_r;

    logic            grant0_s;
    logic            grant1_s;
    logic            idle_s;
    logic [DW-1:0]   sel_a_s;
    logic [DW-1:0]   sel_b_s;
    logic            sel_sub_s;
    logic            sel_cin_s;

    // Round-robin grant: a lone requester always wins, a tie goes to ptr_r.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (r0_valid && r1_valid) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
        end else begin
            grant0_s = r0_valid;
            grant1_s = r1_valid;
        end
    end

    // Operand mux from the granted requester.
    always_comb begin
        sel_a_s   = r0_a;
        sel_b_s   = r0_b;
        sel_sub_s = r0_sub;
        sel_cin_s = r0_cin;
        if (grant1_s) begin
            sel_a_s   = r1_a;
            sel_b_s   = r1_b;
            sel_sub_s = r1_sub;
            sel_cin_s = r1_cin;
        end else begin
            sel_a_s   = r0_a;
            sel_b_s   = r0_b;
            sel_sub_s = r0_sub;
            sel_cin_s = r0_cin;
        end
    end

    assign idle_s   = (state_r == ST_IDLE);
    assign r0_ready = idle_s & grant0_s;
    assign r1_ready = idle_s & grant1_s;

    // Sequencer. The adder drive registers are loaded on acceptance so the
    // adder sees the operands for exactly the EXEC cycle, and they hold their
    // value afterwards so the adder inputs stay quiet while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= RR_INIT_BIT;
            add_a_r     <= '0;
            add_b_r     <= '0;
            add_cin_r   <= 1'b0;
            add_sub_r   <= 1'b0;
            op_id_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_sum_r   <= '0;
            rsp_cout_r  <= 1'b0;
            rsp_ovf_r   <= 1'b0;
            ops_done_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        add_a_r   <= sel_a_s;
                        add_b_r   <= sel_b_s;
                        add_sub_r <= sel_sub_s;
                        // carry-in only means something for add
                        add_cin_r <= sel_sub_s ? 1'b0 : sel_cin_s;
                        op_id_r   <= grant1_s;
                        state_r   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_sum_r   <= add_sum;
                    rsp_cout_r  <= add_cout;
                    rsp_ovf_r   <= ovf_calc(add_sub_r, add_a_r[DW-1],
                                            add_b_r[DW-1], add_sum[DW-1]);
                    rsp_id_r    <= op_id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        ops_done_r  <= ops_done_r + 16'd1;
                        // the requester just served drops to second priority
                        ptr_r       <= ~rsp_id_r;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = add_cin_r;
    assign add_sub   = add_sub_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ovf   = rsp_ovf_r;
    assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_cla16_arb_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cla16_arb_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized run scored against an arithmetic reference model.
// Includes a behavioural stand-in for the external 16-bit add/sub unit.
// -----------------------------------------------------------------------------
module tb_cla16_arb_ctrl;

    logic        clk;
    logic        rst;
    logic        r0_valid, r0_ready, r0_sub, r0_cin;
    logic [15:0] r0_a, r0_b;
    logic        r1_valid, r1_ready, r1_sub, r1_cin;
    logic [15:0] r1_a, r1_b;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_sub, add_cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [15:0] rsp_sum;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;

    cla16_arb_ctrl #(.DW(16), .RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_sub(r0_sub), .r0_cin(r0_cin),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_sub(r1_sub), .r1_cin(r1_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sub(add_sub),
        .add_sum(add_sum), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .ops_done(ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External adder stand-in: subtract is a + ~b + 1.
    always_comb begin
        if (add_sub) {add_cout, add_sum} = {1'b0, add_a} + {1'b0, ~add_b} + 17'd1;
        else         {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    end

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic id, input logic [15:0] a, input logic [15:0] b,
                                input logic sub, input logic cin, input logic [15:0] s,
                                input logic c, input logic o);
        vec_t v;
        v.id = id; v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.e_sum = s; v.e_cout = c; v.e_ovf = o;
        return v;
    endfunction

    // Reference: plain integer arithmetic, overflow = signed result out of range.
    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin,
                                   output logic [15:0] s, output logic c, output logic o);
        int ua, ub, sa, sb, ci, u, sr;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        ci = cin;
        if (sub) begin
            u  = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            u  = ua + ub + ci;
            sr = sa + sb + ci;
            c  = (u > 65535);
        end
        s = u[15:0];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic vld, input logic [15:0] a,
                           input logic [15:0] b, input logic sub, input logic cin);
        if (id == 1'b0) begin
            r0_valid = vld; r0_a = a; r0_b = b; r0_sub = sub; r0_cin = cin;
        end else begin
            r1_valid = vld; r1_a = a; r1_b = b; r1_sub = sub; r1_cin = cin;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated op with rsp_ready high; checks latency, adder drive and result.
    task automatic single_op(input vec_t v);
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(v.id, 1'b1, v.a, v.b, v.sub, v.cin);
        #1;
        chk("grant_ready", v.id ? r1_ready : r0_ready, 1);
        chk("other_ready", v.id ? r0_ready : r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        #1;
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_add_a", add_a, v.a);
        chk("exec_add_b", add_b, v.b);
        chk("exec_add_sub", add_sub, v.sub);
        chk("exec_add_cin", add_cin, v.sub ? 1'b0 : v.cin);
        @(negedge clk);
        #1;
        chk("lat_rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, v.id);
        chk("rsp_sum", rsp_sum, v.e_sum);
        chk("rsp_cout", rsp_cout, v.e_cout);
        chk("rsp_ovf", rsp_ovf, v.e_ovf);
        @(negedge clk);
        #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("hold_add_a", add_a, v.a);
    endtask

    int          got[$];
    logic [15:0] hold_sum;
    logic        m_busy, m_ptr, m_exp_id, m_exp_cout, m_exp_ovf, e0, e1;
    int          m_age;
    logic [15:0] m_done, m_exp_sum;

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r0_a = 16'd0; r0_b = 16'd0; r0_sub = 1'b0; r0_cin = 1'b0;
        r1_valid = 1'b0; r1_a = 16'd0; r1_b = 16'd0; r1_sub = 1'b0; r1_cin = 1'b0;
        rsp_ready = 1'b1;

        vecs[0] = mk(1'b0, 16'd32767, 16'd32768, 1'b0, 1'b0, 16'd65535, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 16'd32767, 16'd16384, 1'b0, 1'b0, 16'd49151, 1'b0, 1'b1);
        vecs[2] = mk(1'b1, 16'd50,    16'd100,   1'b1, 1'b0, 16'hFFCE,  1'b0, 1'b0);
        vecs[3] = mk(1'b1, 16'd100,   16'd100,   1'b1, 1'b0, 16'd0,     1'b1, 1'b0);
        vecs[4] = mk(1'b0, 16'd15,    16'd7,     1'b1, 1'b1, 16'd8,     1'b1, 1'b0);
        vecs[5] = mk(1'b0, 16'hFFFF,  16'h0000,  1'b0, 1'b1, 16'h0000,  1'b1, 1'b0);
        vecs[6] = mk(1'b0, 16'h8000,  16'h8000,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b1);
        vecs[7] = mk(1'b1, 16'h8000,  16'h0001,  1'b1, 1'b0, 16'h7FFF,  1'b1, 1'b1);

        // reset state
        do_reset();
        #1;
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r1_ready", r1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_add_sub", add_sub, 0);
        chk("rst_ops_done", ops_done, 0);

        // directed vector table
        for (int i = 0; i < 8; i++) single_op(vecs[i]);
        #1;
        chk("table_ops_done", ops_done, 16'd8);

        // both requesters valid continuously: alternation 0,1,0,1
        do_reset();
        set_req(1'b0, 1'b1, 16'd15, 16'd7, 1'b1, 1'b1);
        set_req(1'b1, 1'b1, 16'd1000, 16'd24, 1'b0, 1'b0);
        got.delete();
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_ready) begin
                got.push_back(int'(rsp_id));
                if (rsp_id == 1'b0) chk("rr_sum_r0", rsp_sum, 16'd8);
                else                chk("rr_sum_r1", rsp_sum, 16'd1024);
            end
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("rr_resp_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("rr_order", got[i], i % 2);
        @(negedge clk);
        #1;
        chk("rr_ops_done", ops_done, 16'd4);

        // back-pressure: response held for 5 cycles, no new grant meanwhile
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 16'd5, 16'd6, 1'b0, 1'b0);
        set_req(1'b1, 1'b1, 16'd9, 16'd1, 1'b1, 1'b0);
        #1;
        chk("bp_r0_ready", r0_ready, 1);
        chk("bp_r1_ready", r1_ready, 0);
        @(negedge clk);
        r0_valid = 1'b0;
        #1;
        chk("bp_exec_r1_ready", r1_ready, 0);
        @(negedge clk);
        #1;
        chk("bp_rsp_valid", rsp_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_hold_sum", rsp_sum, 16'd11);
            chk("bp_hold_r1_ready", r1_ready, 0);
            chk("bp_hold_ops_done", ops_done, 16'd4);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_idle_r1_ready", r1_ready, 1);
        chk("bp_ops_done", ops_done, 16'd5);
        @(negedge clk);
        r1_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset while in EXEC discards the op
        do_reset();
        set_req(1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b0);
        @(negedge clk);
        r0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rstexec_rsp_valid", rsp_valid, 0);
            chk("rstexec_ops_done", ops_done, 0);
            @(negedge clk);
        end

        // counter wrap from a preloaded value
        force dut.ops_done_r = 16'hFFFE;
        @(negedge clk);
        release dut.ops_done_r;
        #1;
        chk("wrap_preload", ops_done, 16'hFFFE);
        single_op(vecs[0]);
        chk("wrap_ffff", ops_done, 16'hFFFF);
        single_op(vecs[1]);
        chk("wrap_zero", ops_done, 16'h0000);

        // randomized run against the reference model
        do_reset();
        m_busy = 1'b0; m_age = 0; m_ptr = 1'b0; m_done = 16'd0;
        m_exp_id = 1'b0; m_exp_sum = 16'd0; m_exp_cout = 1'b0; m_exp_ovf = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            set_req(1'b0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_req(1'b1, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (m_busy) m_age++;
            e0 = !m_busy && r0_valid && (!r1_valid || !m_ptr);
            e1 = !m_busy && r1_valid && (!r0_valid || m_ptr);
            chk("rnd_r0_ready", r0_ready, e0);
            chk("rnd_r1_ready", r1_ready, e1);
            chk("rnd_rsp_valid", rsp_valid, (m_busy && m_age >= 2));
            chk("rnd_ops_done", ops_done, m_done);
            if (m_busy && m_age >= 2) begin
                chk("rnd_rsp_id", rsp_id, m_exp_id);
                chk("rnd_rsp_sum", rsp_sum, m_exp_sum);
                chk("rnd_rsp_cout", rsp_cout, m_exp_cout);
                chk("rnd_rsp_ovf", rsp_ovf, m_exp_ovf);
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    m_ptr  = ~m_exp_id;
                    m_done = m_done + 16'd1;
                end
            end else if (e0 || e1) begin
                m_exp_id = e1;
                if (e1) ref_op(r1_a, r1_b, r1_sub, r1_cin, m_exp_sum, m_exp_cout, m_exp_ovf);
                else    ref_op(r0_a, r0_b, r0_sub, r0_cin, m_exp_sum, m_exp_cout, m_exp_ovf);
                m_busy = 1'b1;
                m_age  = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
